hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the RV32IM five-stage core. It drives the stall, flush and clear inputs of the inter-stage registers, including the synchronous clear of the decode→execute register and the hold of that register while it is stalled. It also produces the execute-stage operand-forwarding selects. It owns the sequencing of the iterative divider, holding the front of the pipeline while a DIV/DIVU/REM/REMU occupies execute.

## Interface
- DIV_CYCLES, default 32: cycles the iterative divider needs after start; must be ≥1.
- clk  in  1  pipeline clock, rising edge.
- sclr  in  1  synchronous active-high reset.
- rs1_addrD, rs2_addrD  in  5 each  source registers of the instruction in decode.
- rs1_addrE, rs2_addrE, rd_addrE  in  5 each  register addresses of the instruction in execute.
- rd_wrenE  in  1  execute instruction writes rd.
- wb_selE  in  2  execute write-back select; value WB_MEM marks a load.
- is_divE  in  1  execute instruction is DIV/DIVU/REM/REMU.
- br_takenE  in  1  taken branch or jump resolved in execute.
- rd_addrM, rd_addrW  in  5 each  destination registers of the memory and write-back stages.
- rd_wrenM, rd_wrenW  in  1 each  memory/write-back stage writes rd.
- stallF, stallD, stallE  out  1 each  hold the PC, the F/D register and the D/E register respectively.
- flushD  out  1  synchronous clear of the F/D register.
- flushE  out  1  synchronous clear of the D/E register; drives that register's sclr.
- flushM  out  1  synchronous clear of the E/M register (bubble).
- fwd_aE, fwd_bE  out  2 each  ALU operand A/B source: FWD_RF, FWD_W, FWD_M.
- div_startE  out  1  one-cycle pulse; the divider latches its operands and starts.
- div_doneE  out  1  the divider result is valid in execute this cycle.
- div_busy  out  1  divider FSM is not IDLE.

## Operation
- **Forwarding (combinational).**
  - fwd_aE = FWD_M if rd_wrenM, rd_addrM≠0 and rd_addrM==rs1_addrE.
  - Otherwise FWD_W if rd_wrenW, rd_addrW≠0 and rd_addrW==rs1_addrE.
  - Otherwise FWD_RF.
  - fwd_bE is the same rule applied to rs2_addrE. M has priority over W.
- **Load-use.** lu = (wb_selE==WB_MEM) && rd_wrenE && rd_addrE≠0 && (rd_addrE==rs1_addrD || rd_addrE==rs2_addrD).
- **Divider FSM (states IDLE, BUSY, DONE); counter div_cnt is $clog2(DIV_CYCLES+1) bits.**
  - IDLE with is_divE: div_startE=1, div_cnt←DIV_CYCLES-1, go to BUSY.
  - BUSY: div_cnt decrements each cycle. When div_cnt==0, go to DONE.
  - DONE: div_doneE=1 for one cycle, then go to IDLE unconditionally. is_divE is ignored in DONE, so the same instruction cannot retrigger.
  - div_stall = (IDLE && is_divE) || BUSY.
- **Outputs, in priority order:**
  1. div_stall: stallF=stallD=stallE=1, flushM=1, flushD=flushE=0; lu is ignored.
  2. br_takenE: flushD=flushE=1, no stalls; the branch wins over lu.
  3. lu: stallF=stallD=1, flushE=1.
  4. Otherwise all outputs are 0.
- **Divider operands.** The divider captures its operands on div_startE. Forwarding changes during the stall therefore have no effect on the result.

## Timing
- **Reset.** sclr forces state←IDLE and div_cnt←0 at the next edge; sclr has priority over every transition.
  - While sclr is high, all registered state is held at reset.
  - Combinational outputs follow the inputs. With inputs at 0, every output is 0 and fwd is FWD_RF.
  - sclr during BUSY aborts the divide; the FSM is IDLE on the next cycle.
- **Divide occupancy.** A divide in execute stalls for DIV_CYCLES+1 cycles (the start cycle plus DIV_CYCLES BUSY cycles), followed by one DONE cycle. The instruction leaves execute at the end of the DONE cycle.
- **Back-to-back divides.** A second divide reaching execute right after DONE starts immediately from IDLE; there is no dead cycle.
- **Latency.** Forwarding, load-use, branch flush and the start-cycle stall are all zero-latency (combinational).

## Structure
- Package pipeline_pkg holds:
  - WB_MEM = 2'b01.
  - FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - typedef enum {IDLE, BUSY, DONE} div_state_t.
- One sub-module, div_seq_fsm, contains the state register, the counter, div_startE, div_doneE, div_busy and div_stall. Forwarding, load-use detection and priority muxing stay in the top level.

## Test plan
- **Forwarding:**
  - rd_addrM=rd_addrW=5, both with wren, rs1_addrE=5 → fwd_aE=FWD_M.
  - With rd_wrenM=0 → FWD_W.
  - rd_addrM=0 with wren → FWD_RF.
- **Load-use:** wb_selE=WB_MEM, rd_addrE=7, rd_wrenE=1, rs2_addrD=7 → one cycle of stallF=stallD=flushE=1. Same with rd_addrE=0 → no stall.
- **Branch priority:** load-use condition and br_takenE both asserted → flushD=flushE=1, stallF=stallD=0.
- **Divide, DIV_CYCLES=4:** is_divE held high →
  - div_startE pulses in cycle 0.
  - Stalls are high in cycles 0-4.
  - div_doneE=1 in cycle 5, with stalls low.
  - A second is_divE in cycle 6 restarts the sequence.
- **Reset mid-divide:** sclr in the second BUSY cycle → state IDLE, div_busy=0, and stalls follow is_divE from the next cycle.
- **DIV_CYCLES=1 corner case:** stall lasts exactly 2 cycles, then DONE.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard logic: write-back select, forwarding selects, divider states.
// Latency: n/a (types, constants and one combinational helper only).
// Backpressure: n/a.
package pipeline_pkg;

    localparam logic [1:0] WB_MEM = 2'b01;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Operand source for one execute-stage register read; the younger producer (M) wins over W.
    // Register x0 is never forwarded because it always reads as zero.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rsAddr,
        input logic [4:0] rdAddrM,
        input logic       rdWrenM,
        input logic [4:0] rdAddrW,
        input logic       rdWrenW
    );
        if (rdWrenM && (rdAddrM != 5'd0) && (rdAddrM == rsAddr)) begin
            return FWD_M;
        end else if (rdWrenW && (rdAddrW != 5'd0) && (rdAddrW == rsAddr)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/div_seq_fsm.sv
// Sequencer for the iterative divider: start pulse, busy count-down, one-cycle done.
// Latency: start and stall are combinational in the issue cycle; done arrives DIV_CYCLES+1 cycles after start.
// Backpressure: div_stall holds the front of the pipeline for the whole start+busy window.
module div_seq_fsm
    import pipeline_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic sclr,
    input  logic is_divE,
    output logic div_startE,
    output logic div_doneE,
    output logic div_busy,
    output logic div_stall
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    div_state_t       state;
    logic [CNT_W-1:0] divCnt;

    // State and count-down register; the first BUSY cycle already holds DIV_CYCLES-1, so BUSY lasts DIV_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state  <= IDLE;
            divCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_divE) begin
                        state  <= BUSY;
                        divCnt <= CNT_W'(DIV_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (divCnt == '0) begin
                        state <= DONE;
                    end else begin
                        divCnt <= divCnt - 1'b1;
                    end
                end
                // is_divE is deliberately ignored here: the finishing divide is still in execute.
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    divCnt <= '0;
                end
            endcase
        end
    end

    // Start and stall are decoded from the current state plus is_divE so the issue cycle stalls with zero latency.
    always_comb begin
        div_startE = (state == IDLE) && is_divE;
        div_doneE  = (state == DONE);
        div_busy   = (state != IDLE);
        div_stall  = div_startE || (state == BUSY);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control for the five-stage core: forwarding selects, load-use stall, branch flush, divider hold.
// Latency: all stall/flush/forward outputs are combinational; only the divider sequencing is registered.
// Backpressure: a divide outranks a taken branch, which outranks a load-use stall.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       sclr,
    input  logic [4:0] rs1_addrD,
    input  logic [4:0] rs2_addrD,
    input  logic [4:0] rs1_addrE,
    input  logic [4:0] rs2_addrE,
    input  logic [4:0] rd_addrE,
    input  logic       rd_wrenE,
    input  logic [1:0] wb_selE,
    input  logic       is_divE,
    input  logic       br_takenE,
    input  logic [4:0] rd_addrM,
    input  logic [4:0] rd_addrW,
    input  logic       rd_wrenM,
    input  logic       rd_wrenW,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic [1:0] fwd_aE,
    output logic [1:0] fwd_bE,
    output logic       div_startE,
    output logic       div_doneE,
    output logic       div_busy
);

    logic loadUse;
    logic divStall;

    div_seq_fsm #(
        .DIV_CYCLES (DIV_CYCLES)
    ) uDivSeq (
        .clk        (clk),
        .sclr       (sclr),
        .is_divE    (is_divE),
        .div_startE (div_startE),
        .div_doneE  (div_doneE),
        .div_busy   (div_busy),
        .div_stall  (divStall)
    );

    // Operand forwarding and load-use detection against the instruction waiting in decode.
    always_comb begin
        fwd_aE  = fwdSel(rs1_addrE, rd_addrM, rd_wrenM, rd_addrW, rd_wrenW);
        fwd_bE  = fwdSel(rs2_addrE, rd_addrM, rd_wrenM, rd_addrW, rd_wrenW);
        loadUse = (wb_selE == WB_MEM) && rd_wrenE && (rd_addrE != 5'd0) &&
                  ((rd_addrE == rs1_addrD) || (rd_addrE == rs2_addrD));
    end

    // Priority mux: a divide freezes F/D/E and bubbles M; a taken branch squashes D and E;
    // a load-use stalls F/D and inserts a bubble into E.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (divStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (br_takenE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (loadUse) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch priority, divide sequencing and reset.
// Two instances share stimulus: DIV_CYCLES=4 and the DIV_CYCLES=1 corner case.
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_hazard_ctrl;

    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // ctrl vector order: {stallF, stallD, stallE, flushD, flushE, flushM}
    localparam logic [5:0] CTRL_NONE = 6'b000000;
    localparam logic [5:0] CTRL_DIV  = 6'b111001;
    localparam logic [5:0] CTRL_BR   = 6'b000110;
    localparam logic [5:0] CTRL_LU   = 6'b110010;

    logic       clk = 1'b0;
    logic       sclr;
    logic [4:0] rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE, rd_addrE;
    logic       rd_wrenE;
    logic [1:0] wb_selE;
    logic       is_divE, br_takenE;
    logic [4:0] rd_addrM, rd_addrW;
    logic       rd_wrenM, rd_wrenW;

    logic       stallF4, stallD4, stallE4, flushD4, flushE4, flushM4;
    logic [1:0] fwdA4, fwdB4;
    logic       start4, done4, busy4;

    logic       stallF1, stallD1, stallE1, flushD1, flushE1, flushM1;
    logic [1:0] fwdA1, fwdB1;
    logic       start1, done1, busy1;

    logic [5:0] ctrl4, ctrl1;
    assign ctrl4 = {stallF4, stallD4, stallE4, flushD4, flushE4, flushM4};
    assign ctrl1 = {stallF1, stallD1, stallE1, flushD1, flushE1, flushM1};

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DIV_CYCLES(4)) uDut4 (
        .clk(clk), .sclr(sclr),
        .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD),
        .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE), .rd_addrE(rd_addrE),
        .rd_wrenE(rd_wrenE), .wb_selE(wb_selE), .is_divE(is_divE), .br_takenE(br_takenE),
        .rd_addrM(rd_addrM), .rd_addrW(rd_addrW), .rd_wrenM(rd_wrenM), .rd_wrenW(rd_wrenW),
        .stallF(stallF4), .stallD(stallD4), .stallE(stallE4),
        .flushD(flushD4), .flushE(flushE4), .flushM(flushM4),
        .fwd_aE(fwdA4), .fwd_bE(fwdB4),
        .div_startE(start4), .div_doneE(done4), .div_busy(busy4)
    );

    hazard_ctrl #(.DIV_CYCLES(1)) uDut1 (
        .clk(clk), .sclr(sclr),
        .rs1_addrD(rs1_addrD), .rs2_addrD(rs2_addrD),
        .rs1_addrE(rs1_addrE), .rs2_addrE(rs2_addrE), .rd_addrE(rd_addrE),
        .rd_wrenE(rd_wrenE), .wb_selE(wb_selE), .is_divE(is_divE), .br_takenE(br_takenE),
        .rd_addrM(rd_addrM), .rd_addrW(rd_addrW), .rd_wrenM(rd_wrenM), .rd_wrenW(rd_wrenW),
        .stallF(stallF1), .stallD(stallD1), .stallE(stallE1),
        .flushD(flushD1), .flushE(flushE1), .flushM(flushM1),
        .fwd_aE(fwdA1), .fwd_bE(fwdB1),
        .div_startE(start1), .div_doneE(done1), .div_busy(busy1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nTests++;
        if (obs !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, ready to drive.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rs1_addrD = '0; rs2_addrD = '0; rs1_addrE = '0; rs2_addrE = '0; rd_addrE = '0;
        rd_wrenE = 1'b0; wb_selE = '0; is_divE = 1'b0; br_takenE = 1'b0;
        rd_addrM = '0; rd_addrW = '0; rd_wrenM = 1'b0; rd_wrenW = 1'b0;
    endtask

    // Divide timeline check for the DIV_CYCLES=4 instance.
    task automatic chkDiv4(input string tag, input logic [5:0] ctrlExp,
                           input logic startExp, input logic doneExp, input logic busyExp);
        chk({tag, ".ctrl"},  8'(ctrl4),  8'(ctrlExp));
        chk({tag, ".start"}, 8'(start4), 8'(startExp));
        chk({tag, ".done"},  8'(done4),  8'(doneExp));
        chk({tag, ".busy"},  8'(busy4),  8'(busyExp));
    endtask

    task automatic chkDiv1(input string tag, input logic [5:0] ctrlExp,
                           input logic startExp, input logic doneExp, input logic busyExp);
        chk({tag, ".ctrl"},  8'(ctrl1),  8'(ctrlExp));
        chk({tag, ".start"}, 8'(start1), 8'(startExp));
        chk({tag, ".done"},  8'(done1),  8'(doneExp));
        chk({tag, ".busy"},  8'(busy1),  8'(busyExp));
    endtask

    initial begin
        clearInputs();
        sclr = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        chkDiv4("rst4", CTRL_NONE, 1'b0, 1'b0, 1'b0);
        chk("rst.fwdA", 8'(fwdA4), 8'(FWD_RF));
        chk("rst.fwdB", 8'(fwdB4), 8'(FWD_RF));
        chkDiv1("rst1", CTRL_NONE, 1'b0, 1'b0, 1'b0);

        nextCycle();
        sclr = 1'b0;

        // Forwarding: M beats W, then W alone, then x0 is never forwarded.
        rd_addrM = 5'd5; rd_addrW = 5'd5; rd_wrenM = 1'b1; rd_wrenW = 1'b1;
        rs1_addrE = 5'd5; rs2_addrE = 5'd6;
        @(negedge clk);
        chk("fwd.mPrio.a", 8'(fwdA4), 8'(FWD_M));
        chk("fwd.mPrio.b", 8'(fwdB4), 8'(FWD_RF));
        nextCycle();
        rd_wrenM = 1'b0; rs2_addrE = 5'd5;
        @(negedge clk);
        chk("fwd.wOnly.a", 8'(fwdA4), 8'(FWD_W));
        chk("fwd.wOnly.b", 8'(fwdB4), 8'(FWD_W));
        nextCycle();
        rd_addrM = 5'd0; rd_wrenM = 1'b1; rd_addrW = 5'd0; rs1_addrE = 5'd0;
        @(negedge clk);
        chk("fwd.x0.a", 8'(fwdA4), 8'(FWD_RF));
        nextCycle();
        rd_addrM = 5'd9; rd_wrenM = 1'b1; rd_addrW = 5'd3; rd_wrenW = 1'b1;
        rs1_addrE = 5'd3; rs2_addrE = 5'd9;
        @(negedge clk);
        chk("fwd.split.a", 8'(fwdA4), 8'(FWD_W));
        chk("fwd.split.b", 8'(fwdB4), 8'(FWD_M));
        chk("fwd.noStall", 8'(ctrl4), 8'(CTRL_NONE));
        nextCycle();
        clearInputs();

        // Load-use on rs2, then the same with rd=x0, then a non-load producer.
        wb_selE = WB_MEM; rd_addrE = 5'd7; rd_wrenE = 1'b1; rs2_addrD = 5'd7; rs1_addrD = 5'd2;
        @(negedge clk);
        chk("lu.hit", 8'(ctrl4), 8'(CTRL_LU));
        nextCycle();
        wb_selE = 2'b00;
        @(negedge clk);
        chk("lu.released", 8'(ctrl4), 8'(CTRL_NONE));
        nextCycle();
        wb_selE = WB_MEM; rd_addrE = 5'd0; rs2_addrD = 5'd0;
        @(negedge clk);
        chk("lu.x0", 8'(ctrl4), 8'(CTRL_NONE));
        nextCycle();
        wb_selE = 2'b10; rd_addrE = 5'd7; rs1_addrD = 5'd7;
        @(negedge clk);
        chk("lu.notLoad", 8'(ctrl4), 8'(CTRL_NONE));

        // Taken branch wins over a live load-use.
        nextCycle();
        wb_selE = WB_MEM; br_takenE = 1'b1;
        @(negedge clk);
        chk("br.overLu", 8'(ctrl4), 8'(CTRL_BR));
        nextCycle();
        clearInputs();

        // Divide, DIV_CYCLES=4: start in cycle 0, stall 0..4, done in 5, restart in 6.
        is_divE = 1'b1;
        @(negedge clk);
        chkDiv4("div.c0", CTRL_DIV, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            // A taken branch or load-use during the divide must not leak through.
            br_takenE = (c == 2);
            wb_selE = (c == 3) ? WB_MEM : 2'b00;
            rd_addrE = 5'd4; rd_wrenE = 1'b1; rs1_addrD = 5'd4;
            @(negedge clk);
            chkDiv4($sformatf("div.c%0d", c), CTRL_DIV, 1'b0, 1'b0, 1'b1);
        end
        nextCycle();
        br_takenE = 1'b0; wb_selE = 2'b00; rd_wrenE = 1'b0;
        @(negedge clk);
        chkDiv4("div.c5", CTRL_NONE, 1'b0, 1'b1, 1'b1);
        nextCycle();
        @(negedge clk);
        chkDiv4("div.c6", CTRL_DIV, 1'b1, 1'b0, 1'b0);
        nextCycle();
        @(negedge clk);
        chkDiv4("div.c7", CTRL_DIV, 1'b0, 1'b0, 1'b1);

        // Reset in the second BUSY cycle aborts the divide.
        nextCycle();
        sclr = 1'b1;
        @(negedge clk);
        chkDiv4("rstMid.c8", CTRL_DIV, 1'b0, 1'b0, 1'b1);
        nextCycle();
        sclr = 1'b0; is_divE = 1'b0;
        @(negedge clk);
        chkDiv4("rstMid.c9", CTRL_NONE, 1'b0, 1'b0, 1'b0);
        nextCycle();
        is_divE = 1'b1;
        @(negedge clk);
        chkDiv4("rstMid.c10", CTRL_DIV, 1'b1, 1'b0, 1'b0);

        // DIV_CYCLES=1: two stall cycles, then DONE.
        nextCycle();
        sclr = 1'b1; is_divE = 1'b0;
        nextCycle();
        sclr = 1'b0; is_divE = 1'b1;
        @(negedge clk);
        chkDiv1("div1.c0", CTRL_DIV, 1'b1, 1'b0, 1'b0);
        nextCycle();
        @(negedge clk);
        chkDiv1("div1.c1", CTRL_DIV, 1'b0, 1'b0, 1'b1);
        nextCycle();
        @(negedge clk);
        chkDiv1("div1.c2", CTRL_NONE, 1'b0, 1'b1, 1'b1);
        nextCycle();
        is_divE = 1'b0;
        @(negedge clk);
        chkDiv1("div1.c3", CTRL_NONE, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
